// File: rtl/qspi_gear_fifo_if.sv
// qspi_gear_fifo_if
//   Handshake and status bundle for the QSPI width-converting FIFO.
//   Optional macro: QSPI_FIFO_SNOOP_EN adds the snoop window signal.
//   master : producer/consumer side (drives clear, push, push_data, pop)
//   slave  : FIFO side (drives push_ready, pop_data, pop_valid, flags, count)
interface qspi_gear_fifo_if #(
   parameter int unsigned IN_W    = 4,
   parameter int unsigned OUT_W   = 2,
   parameter int unsigned DEPTH   = 24,
   parameter int unsigned SNOOP_W = 32
);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic             clear;
   logic             push;
   logic [IN_W-1:0]  push_data;
   logic             push_ready;
   logic             pop;
   logic [OUT_W-1:0] pop_data;
   logic             pop_valid;
   logic             empty;
   logic             full;
   logic             almost_full;
   logic [CW-1:0]    count;
   logic             overflow;
   logic             underflow;
`ifdef QSPI_FIFO_SNOOP_EN
   logic [SNOOP_W-1:0] snoop;
`endif

   modport master (
      output clear, push, push_data, pop,
      input  push_ready, pop_data, pop_valid, empty, full, almost_full,
      input  count, overflow, underflow
`ifdef QSPI_FIFO_SNOOP_EN
      , input snoop
`endif
   );

   modport slave (
      input  clear, push, push_data, pop,
      output push_ready, pop_data, pop_valid, empty, full, almost_full,
      output count, overflow, underflow
`ifdef QSPI_FIFO_SNOOP_EN
      , output snoop
`endif
   );
endinterface

// File: rtl/qspi_gear_fifo.sv
// qspi_gear_fifo
//   Width-converting ring-buffer FIFO: accepts IN_W-bit words, emits OUT_W-bit
//   slices MSB-first, one registered slice per accepted pop (1-cycle latency).
//   Sticky overflow/underflow, almost_full watermark, synchronous clear.
//   Optional macro: QSPI_FIFO_SNOOP_EN keeps the last SNOOP_W/IN_W pushed words.
// Ports
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   bus    : qspi_gear_fifo_if.slave (clear, push/push_data/push_ready,
//            pop/pop_data/pop_valid, empty, full, almost_full, count,
//            overflow, underflow, snoop when enabled)
module qspi_gear_fifo #(
   parameter int unsigned IN_W     = 4,
   parameter int unsigned OUT_W    = 2,
   parameter int unsigned DEPTH    = 24,
   parameter int unsigned AF_LEVEL = 20,
   parameter int unsigned SNOOP_W  = 32
) (
   input logic              clk,
   input logic              rst_n,
   qspi_gear_fifo_if.slave  bus
);
   localparam int unsigned R  = IN_W / OUT_W;
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   if (IN_W % OUT_W != 0) begin : g_chk_ratio
      $error("qspi_gear_fifo: IN_W must be a multiple of OUT_W");
   end
   if (DEPTH < 2 * R) begin : g_chk_depth
      $error("qspi_gear_fifo: DEPTH must be at least 2*IN_W/OUT_W");
   end
   if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_chk_af
      $error("qspi_gear_fifo: AF_LEVEL must be within 1..DEPTH");
   end
   if (SNOOP_W % IN_W != 0) begin : g_chk_snoop
      $error("qspi_gear_fifo: SNOOP_W must be a multiple of IN_W");
   end

   // Pointer advance with wrap at DEPTH, which need not be a power of two.
   function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p,
                                              input int unsigned n);
      int unsigned s;
      s = 32'(p) + n;
      if (s >= DEPTH) s = s - DEPTH;
      return PW'(s);
   endfunction

   logic [OUT_W-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [OUT_W-1:0] pop_data_q, pop_data_d;
   logic             pop_valid_q, pop_valid_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;
   logic             push_ready, empty, push_acc, pop_acc;

   // Flags come from the start-of-cycle count, so a same-cycle push never
   // makes a pop on an empty FIFO legal.
   assign push_ready = (CW'(DEPTH) - count_q) >= CW'(R);
   assign empty      = (count_q == '0);
   assign push_acc   = bus.push && push_ready;
   assign pop_acc    = bus.pop && !empty;

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      pop_data_d  = pop_data_q;
      pop_valid_d = 1'b0;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (bus.clear) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         count_d     = '0;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end else begin
         if (push_acc) begin
            wr_ptr_d = wrap_add(wr_ptr_q, R);
         end else if (bus.push) begin
            overflow_d = 1'b1;
         end
         if (pop_acc) begin
            pop_data_d  = mem_q[rd_ptr_q];
            pop_valid_d = 1'b1;
            rd_ptr_d    = wrap_add(rd_ptr_q, 1);
         end else if (bus.pop) begin
            underflow_d = 1'b1;
         end
         count_d = count_q + CW'(push_acc ? R : 32'd0) - CW'(pop_acc ? 32'd1 : 32'd0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         pop_data_q  <= '0;
         pop_valid_q <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         pop_data_q  <= pop_data_d;
         pop_valid_q <= pop_valid_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage is not reset; slice 0 (MSB slice) lands at wr_ptr.
   always_ff @(posedge clk) begin
      if (push_acc && !bus.clear) begin
         for (int unsigned i = 0; i < R; i++) begin
            mem_q[wrap_add(wr_ptr_q, i)] <= bus.push_data[IN_W-1-i*OUT_W -: OUT_W];
         end
      end
   end

`ifdef QSPI_FIFO_SNOOP_EN
   logic [SNOOP_W-1:0] snoop_q, snoop_d;

   // Shift register of pushed words, newest in the LSBs; pops do not touch it.
   always_comb begin
      snoop_d = snoop_q;
      if (bus.clear) begin
         snoop_d = '0;
      end else if (push_acc) begin
         snoop_d = (snoop_q << IN_W) | SNOOP_W'(bus.push_data);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) snoop_q <= '0;
      else        snoop_q <= snoop_d;
   end

   assign bus.snoop = snoop_q;
`endif

   assign bus.push_ready  = push_ready;
   assign bus.full        = !push_ready;
   assign bus.empty       = empty;
   assign bus.almost_full = (count_q >= CW'(AF_LEVEL));
   assign bus.count       = count_q;
   assign bus.pop_data    = pop_data_q;
   assign bus.pop_valid   = pop_valid_q;
   assign bus.overflow    = overflow_q;
   assign bus.underflow   = underflow_q;
endmodule
